// File: rtl/ofdm_syn_buf_ctrl.sv
// Ping-pong frame buffer controller: writes received frames into two DPRAM banks and
// replays each one from the sync-detector offset onward through a 2-entry output FIFO.
module ofdm_syn_buf_ctrl #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned SYN_DATA_WIDTH = 13
) (
   input  logic                      axis_aclk,
   input  logic                      axis_arst,
   input  logic                      s_axis_data_tvalid,
   input  logic                      s_axis_data_tlast,
   input  logic [DATA_WIDTH-1:0]     s_axis_data_tdata,
   output logic                      s_axis_data_trdy,
   input  logic                      s_axis_ctrl_tvalid,
   input  logic [SYN_DATA_WIDTH-1:0] s_axis_ctrl_tdata,
   output logic                      s_axis_ctrl_trdy,
   output logic                      m_axis_data_tvalid,
   output logic                      m_axis_data_tlast,
   output logic [DATA_WIDTH-1:0]     m_axis_data_tdata,
   input  logic                      m_axis_data_trdy,
   output logic                      ram_wr_en,
   output logic [SYN_DATA_WIDTH:0]   ram_wr_addr,
   output logic [DATA_WIDTH-1:0]     ram_wr_data,
   output logic                      ram_rd_en,
   output logic [SYN_DATA_WIDTH:0]   ram_rd_addr,
   input  logic [DATA_WIDTH-1:0]     ram_rd_data,
   output logic                      offset_err
);

   localparam int unsigned AW = SYN_DATA_WIDTH;
   localparam logic [AW-1:0] CntMax = {AW{1'b1}};
   localparam logic [AW:0]   LenOne = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                state_q, state_d;
   logic [1:0]            full_q, full_d;
   logic [AW:0]           len_q [2];
   logic [AW:0]           len_d [2];
   logic                  wr_bank_q, wr_bank_d;
   logic [AW-1:0]         wr_cnt_q, wr_cnt_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [AW-1:0]         rd_cnt_q, rd_cnt_d;
   logic                  offset_err_q, offset_err_d;
   logic                  inflight_q, inflight_last_q;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [1:0]            fifo_last_q;
   logic                  fifo_wptr_q, fifo_rptr_q;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;

   logic                  wr_fire, wr_close, ctrl_fire, offset_ok;
   logic                  rd_last, fifo_pop, rd_clr;
   logic [AW:0]           cur_len;
   logic [1:0]            occ;

   always_comb begin
      s_axis_data_trdy = !axis_arst && !full_q[wr_bank_q];
      wr_fire          = s_axis_data_tvalid && s_axis_data_trdy;
      wr_close         = wr_fire && (s_axis_data_tlast || (wr_cnt_q == CntMax));
      ram_wr_en        = wr_fire;
      ram_wr_addr      = wr_fire ? {wr_bank_q, wr_cnt_q} : '0;
      ram_wr_data      = wr_fire ? s_axis_data_tdata : '0;

      cur_len          = len_q[rd_bank_q];
      s_axis_ctrl_trdy = !axis_arst && (state_q == StIdle) && full_q[rd_bank_q];
      ctrl_fire        = s_axis_ctrl_tvalid && s_axis_ctrl_trdy;
      offset_ok        = {1'b0, s_axis_ctrl_tdata} < cur_len;

      m_axis_data_tvalid = (fifo_cnt_q != 2'd0);
      m_axis_data_tdata  = fifo_data_q[fifo_rptr_q];
      m_axis_data_tlast  = fifo_last_q[fifo_rptr_q];
      fifo_pop           = m_axis_data_tvalid && m_axis_data_trdy;

      // Crediting the current pop lets a read issue every cycle once streaming.
      occ         = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};
      ram_rd_en   = (state_q == StRun) && (occ < 2'd2);
      ram_rd_addr = ram_rd_en ? {rd_bank_q, rd_cnt_q} : '0;
      rd_last     = ({1'b0, rd_cnt_q} == (cur_len - LenOne));

      rd_clr = (ctrl_fire && !offset_ok) ||
               ((state_q == StDrain) && (fifo_cnt_q == 2'd0) && !inflight_q);
      offset_err = offset_err_q;
   end

   always_comb begin
      state_d      = state_q;
      full_d       = full_q;
      len_d        = len_q;
      wr_bank_d    = wr_bank_q;
      wr_cnt_d     = wr_cnt_q;
      rd_bank_d    = rd_bank_q;
      rd_cnt_d     = rd_cnt_q;
      offset_err_d = ctrl_fire && !offset_ok;
      fifo_cnt_d   = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_close) begin
            len_d[wr_bank_q]  = {1'b0, wr_cnt_q} + LenOne;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_cnt_d          = '0;
         end
      end

      // Writer only targets a non-full bank, reader only clears a full one.
      if (rd_clr) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end

      unique case (state_q)
         StIdle: begin
            if (ctrl_fire && offset_ok) begin
               rd_cnt_d = s_axis_ctrl_tdata;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (ram_rd_en) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_last) state_d = StDrain;
            end
         end
         StDrain: begin
            if (rd_clr) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axis_aclk or posedge axis_arst) begin
      if (axis_arst) begin
         state_q         <= StIdle;
         full_q          <= '0;
         len_q[0]        <= '0;
         len_q[1]        <= '0;
         wr_bank_q       <= 1'b0;
         wr_cnt_q        <= '0;
         rd_bank_q       <= 1'b0;
         rd_cnt_q        <= '0;
         offset_err_q    <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= '0;
         fifo_data_q[1]  <= '0;
         fifo_last_q     <= '0;
         fifo_wptr_q     <= 1'b0;
         fifo_rptr_q     <= 1'b0;
         fifo_cnt_q      <= '0;
      end else begin
         state_q         <= state_d;
         full_q          <= full_d;
         len_q[0]        <= len_d[0];
         len_q[1]        <= len_d[1];
         wr_bank_q       <= wr_bank_d;
         wr_cnt_q        <= wr_cnt_d;
         rd_bank_q       <= rd_bank_d;
         rd_cnt_q        <= rd_cnt_d;
         offset_err_q    <= offset_err_d;
         inflight_q      <= ram_rd_en;
         inflight_last_q <= ram_rd_en && rd_last;
         if (inflight_q) begin
            fifo_data_q[fifo_wptr_q] <= ram_rd_data;
            fifo_last_q[fifo_wptr_q] <= inflight_last_q;
            fifo_wptr_q              <= !fifo_wptr_q;
         end
         if (fifo_pop) fifo_rptr_q <= !fifo_rptr_q;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_ofdm_syn_buf_ctrl.sv
// Bench for ofdm_syn_buf_ctrl: random frames through a DPRAM model, expected output taken
// from a frame-level reference (samples[offset..len-1] of each stored frame).
module tb_ofdm_syn_buf_ctrl;

   localparam int DW = 16;
   localparam int SW = 13;
   localparam int FL = 1 << SW;
   localparam int ALL = 2 * FL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_trdy;
   logic          c_tvalid = 1'b0;
   logic [SW-1:0] c_tdata = '0;
   logic          c_trdy;
   logic          m_tvalid, m_tlast;
   logic [DW-1:0] m_tdata;
   logic          m_trdy = 1'b0;
   logic          wr_en, rd_en, off_err;
   logic [SW:0]   wr_addr, rd_addr;
   logic [DW-1:0] wr_data, rd_data;

   always #5 clk = ~clk;

   ofdm_syn_buf_ctrl #(.DATA_WIDTH(DW), .SYN_DATA_WIDTH(SW)) dut (
      .axis_aclk          (clk),
      .axis_arst          (rst),
      .s_axis_data_tvalid (s_tvalid),
      .s_axis_data_tlast  (s_tlast),
      .s_axis_data_tdata  (s_tdata),
      .s_axis_data_trdy   (s_trdy),
      .s_axis_ctrl_tvalid (c_tvalid),
      .s_axis_ctrl_tdata  (c_tdata),
      .s_axis_ctrl_trdy   (c_trdy),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tlast  (m_tlast),
      .m_axis_data_tdata  (m_tdata),
      .m_axis_data_trdy   (m_trdy),
      .ram_wr_en          (wr_en),
      .ram_wr_addr        (wr_addr),
      .ram_wr_data        (wr_data),
      .ram_rd_en          (rd_en),
      .ram_rd_addr        (rd_addr),
      .ram_rd_data        (rd_data),
      .offset_err         (off_err)
   );

   // Dual-port RAM, one-cycle read latency.
   logic [DW-1:0] ram [ALL];
   always @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
      if (rd_en) rd_data <= ram[rd_addr];
   end

   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] smp_q [$];
   int            flen_q [$];
   logic [DW-1:0] exp_q [$];
   int            wcnt = 0;
   bit            chk_wr0 = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_s_trdy"}, s_trdy, 0);
      check({tag, "_c_trdy"}, c_trdy, 0);
      check({tag, "_m_tvalid"}, m_tvalid, 0);
      check({tag, "_m_tlast"}, m_tlast, 0);
      check({tag, "_m_tdata"}, m_tdata, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_offset_err"}, off_err, 0);
   endtask

   // Frame model: a frame ends on tlast or after FL samples.
   task automatic push_sample(input logic [DW-1:0] d, input bit last);
      bit ok = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      for (int t = 0; t < 40000 && !ok; t++) begin
         @(negedge clk);
         ok = s_trdy;
      end
      check("wr_handshake", ok, 1);
      if (chk_wr0) begin
         check("wr_addr_after_rst", wr_addr, 0);
         chk_wr0 = 1'b0;
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      smp_q.push_back(d);
      wcnt++;
      if (last || wcnt == FL) begin
         flen_q.push_back(wcnt);
         wcnt = 0;
      end
   endtask

   task automatic write_frame(input int n, input bit with_last);
      for (int i = 0; i < n; i++) push_sample(DW'($urandom), with_last && (i == n - 1));
   endtask

   task automatic send_ctrl(input int off);
      bit ok = 1'b0;
      c_tvalid = 1'b1;
      c_tdata  = SW'(off);
      for (int t = 0; t < 40000 && !ok; t++) begin
         @(negedge clk);
         ok = c_trdy;
      end
      check("ctrl_handshake", ok, 1);
      @(posedge clk);
      #1;
      c_tvalid = 1'b0;
   endtask

   task automatic build_exp(input int off);
      int            len;
      logic [DW-1:0] d;
      len = flen_q.pop_front();
      exp_q.delete();
      for (int i = 0; i < len; i++) begin
         d = smp_q.pop_front();
         if (i >= off) exp_q.push_back(d);
      end
   endtask

   // Called in the cycle right after the ctrl handshake.
   task automatic drain(input int stop_after, input bit rnd);
      int            n = exp_q.size();
      int            want = (stop_after < n) ? stop_after : n;
      int            k = 0;
      int            first = -1;
      int            lastc = -1;
      logic          held = 1'b0;
      logic [DW-1:0] hd = '0;
      logic          hl = 1'b0;
      for (int cyc = 1; cyc <= n * 4 + 100 && k < want; cyc++) begin
         m_trdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (cyc == 1) check("rd_en_first_cycle", rd_en, 1);
         if (held) begin
            check("stall_valid", m_tvalid, 1);
            check("stall_data", m_tdata, hd);
            check("stall_last", m_tlast, hl);
         end
         if (m_tvalid && first < 0) begin
            first = cyc;
            check("first_valid_latency", cyc, 3);
         end
         if (m_tvalid && m_trdy) begin
            check("extra_out", k < n, 1);
            if (k < n) begin
               check("out_data", m_tdata, exp_q[k]);
               check("out_last", m_tlast, k == n - 1);
            end
            k++;
            lastc = cyc;
            held  = 1'b0;
         end else begin
            held = m_tvalid;
            hd   = m_tdata;
            hl   = m_tlast;
         end
         @(posedge clk);
         #1;
      end
      m_trdy = 1'b0;
      check("out_count", k, want);
      if (!rnd && k == n) check("no_bubble", lastc - first, n - 1);
   endtask

   task automatic tail_idle(input string tag);
      repeat (3) begin
         @(negedge clk);
         check({tag, "_no_extra"}, m_tvalid, 0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int off, la, lb, oa, ob;

      // Reset with every input asserted.
      s_tvalid = 1'b1;
      s_tdata  = 16'hABCD;
      s_tlast  = 1'b1;
      c_tvalid = 1'b1;
      m_trdy   = 1'b1;
      #12;
      check_zero("rst");
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      c_tvalid = 1'b0;
      m_trdy   = 1'b0;
      #11 rst = 1'b0;
      @(posedge clk);
      #1;

      // 100-sample frame, offset 10.
      write_frame(100, 1);
      send_ctrl(10);
      build_exp(10);
      drain(ALL, 0);
      tail_idle("f100");

      // Two full-length frames without tlast fill both banks.
      write_frame(FL, 0);
      write_frame(FL, 0);
      s_tvalid = 1'b1;
      s_tdata  = 16'h1234;
      @(negedge clk);
      check("both_full_trdy", s_trdy, 0);
      check("both_full_wr_en", wr_en, 0);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      send_ctrl(0);
      build_exp(0);
      drain(ALL, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bank_freed_trdy", s_trdy, 1);
      @(posedge clk);
      #1;
      off = $urandom_range(0, FL - 1);
      send_ctrl(off);
      build_exp(off);
      drain(ALL, 0);
      tail_idle("full");

      // Offset beyond frame length: frame dropped, next bank served.
      write_frame(50, 1);
      write_frame(30, 1);
      send_ctrl(100);
      build_exp(100);
      @(negedge clk);
      check("err_pulse", off_err, 1);
      check("err_freed_trdy", s_trdy, 1);
      check("err_no_rd", rd_en, 0);
      check("err_no_out", m_tvalid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("err_single_pulse", off_err, 0);
      check("err_no_out2", m_tvalid, 0);
      @(posedge clk);
      #1;
      off = $urandom_range(0, 29);
      send_ctrl(off);
      build_exp(off);
      drain(ALL, 0);
      tail_idle("err");

      // Four random frames with random output backpressure.
      for (int f = 0; f < 4; f += 2) begin
         la = $urandom_range(20, 200);
         lb = $urandom_range(20, 200);
         write_frame(la, 1);
         write_frame(lb, 1);
         oa = $urandom_range(0, la - 1);
         send_ctrl(oa);
         build_exp(oa);
         drain(ALL, 1);
         ob = (f == 0) ? lb - 1 : $urandom_range(0, lb - 1);
         send_ctrl(ob);
         build_exp(ob);
         drain(ALL, 1);
      end
      tail_idle("rnd");

      // Reset while streaming.
      write_frame(200, 1);
      send_ctrl(0);
      build_exp(0);
      drain(10, 0);
      s_tvalid = 1'b1;
      s_tdata  = 16'h5A5A;
      c_tvalid = 1'b1;
      m_trdy   = 1'b1;
      #1 rst = 1'b1;
      #1 check_zero("run_rst");
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      c_tvalid = 1'b0;
      m_trdy   = 1'b0;
      #2 rst = 1'b0;
      smp_q.delete();
      flen_q.delete();
      exp_q.delete();
      wcnt = 0;
      @(posedge clk);
      #1;
      chk_wr0 = 1'b1;
      write_frame(64, 1);
      off = $urandom_range(0, 63);
      send_ctrl(off);
      build_exp(off);
      drain(ALL, 0);
      tail_idle("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
